// File: rtl/mem_arbiter_if.sv
// Bundle between mem_arbiter and its clients: I/D-cache miss handlers, store path, main memory.
// The master modport is the arbiter's view; the slave modport is the caches/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
);
  localparam int WIDX_W = $clog2(WORDS);

  logic              i_miss_req;
  logic [ADDR_W-1:0] i_miss_addr;
  logic              d_miss_req;
  logic [ADDR_W-1:0] d_miss_addr;
  logic              d_wr_req;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [DATA_W-1:0] d_wr_data;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] fill_data;
  logic [WIDX_W-1:0] fill_word;
  logic              i_fill_we;
  logic              d_fill_we;
  logic              i_fill_done;
  logic              d_fill_done;
  logic              d_wr_ack;
  logic              i_cache_busy;
  logic              d_cache_busy;

  modport master (
    input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
           d_wr_req, d_wr_addr, d_wr_data, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
           i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack,
           i_cache_busy, d_cache_busy
  );

  modport slave (
    output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
           d_wr_req, d_wr_addr, d_wr_data, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
           i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack,
           i_cache_busy, d_cache_busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: block fills for I/D caches and write-through stores.
// Define MEM_ARB_RR_EN for round-robin between I and D misses (default: D over I).
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int WORDS   = 8,
  parameter int MEM_LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.master  bus
);
  localparam int WIDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_e;

  state_e            state_q;
  logic              mem_en_q;
  logic              mem_wr_q;
  logic              wr_ack_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [WIDX_W-1:0] cnt_q;
  logic [MEM_LAT-1:0] vld_q;
  logic [WIDX_W-1:0] idx_q [MEM_LAT];
  logic              mask_wr_q;
  logic              mask_d_q;
  logic              mask_i_q;
`ifdef MEM_ARB_RR_EN
  logic              last_miss_q;
`endif

  logic wr_ok, dm_ok, im_ok, pick_d;
  logic grant_wr, grant_d, grant_i;
  logic issue_rd, ret_vld, ret_last;

  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(WORDS * 2 - 1);
  endfunction

  // A request just served is ignored for the one IDLE cycle that follows its done/ack.
  assign wr_ok = bus.d_wr_req   & ~mask_wr_q;
  assign dm_ok = bus.d_miss_req & ~mask_d_q;
  assign im_ok = bus.i_miss_req & ~mask_i_q;
`ifdef MEM_ARB_RR_EN
  assign pick_d = dm_ok & (~im_ok | ~last_miss_q);
`else
  assign pick_d = dm_ok;
`endif
  assign grant_wr = wr_ok;
  assign grant_d  = ~wr_ok & pick_d;
  assign grant_i  = ~wr_ok & ~pick_d & im_ok;

  assign issue_rd = mem_en_q & ~mem_wr_q;
  assign ret_vld  = vld_q[MEM_LAT-1];
  assign ret_last = ret_vld && (idx_q[MEM_LAT-1] == WIDX_W'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
      vld_q       <= '0;
      mask_wr_q   <= 1'b0;
      mask_d_q    <= 1'b0;
      mask_i_q    <= 1'b0;
      for (int j = 0; j < MEM_LAT; j++) idx_q[j] <= '0;
`ifdef MEM_ARB_RR_EN
      last_miss_q <= 1'b0;
`endif
    end else begin
      // Return pipeline: a read issued now returns MEM_LAT cycles later
      for (int j = MEM_LAT - 1; j > 0; j--) begin
        vld_q[j] <= vld_q[j-1];
        idx_q[j] <= idx_q[j-1];
      end
      vld_q[0] <= issue_rd;
      idx_q[0] <= cnt_q;

      wr_ack_q  <= 1'b0;
      mask_wr_q <= 1'b0;
      mask_d_q  <= 1'b0;
      mask_i_q  <= 1'b0;

      unique case (state_q)
        IDLE: begin
          mem_en_q <= 1'b0;
          mem_wr_q <= 1'b0;
          cnt_q    <= '0;
          if (grant_wr) begin
            state_q     <= WRITE;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= bus.d_wr_addr;
            mem_wdata_q <= bus.d_wr_data;
            wr_ack_q    <= 1'b1;
          end else if (grant_d) begin
            state_q    <= FILL_D;
            mem_en_q   <= 1'b1;
            mem_addr_q <= block_base(bus.d_miss_addr);
`ifdef MEM_ARB_RR_EN
            last_miss_q <= 1'b1;
`endif
          end else if (grant_i) begin
            state_q    <= FILL_I;
            mem_en_q   <= 1'b1;
            mem_addr_q <= block_base(bus.i_miss_addr);
`ifdef MEM_ARB_RR_EN
            last_miss_q <= 1'b0;
`endif
          end
        end
        WRITE: begin
          state_q   <= IDLE;
          mem_en_q  <= 1'b0;
          mem_wr_q  <= 1'b0;
          mask_wr_q <= 1'b1;
        end
        FILL_I, FILL_D: begin
          if (mem_en_q) begin
            cnt_q      <= cnt_q + WIDX_W'(1);
            mem_addr_q <= mem_addr_q + ADDR_W'(2);
            if (cnt_q == WIDX_W'(WORDS - 1)) mem_en_q <= 1'b0;
          end
          if (ret_last) begin
            state_q  <= IDLE;
            mask_i_q <= (state_q == FILL_I);
            mask_d_q <= (state_q == FILL_D);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_en       = mem_en_q;
  assign bus.mem_wr       = mem_wr_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.d_wr_ack     = wr_ack_q;
  assign bus.fill_data    = bus.mem_rdata;
  assign bus.fill_word    = idx_q[MEM_LAT-1];
  assign bus.i_fill_we    = ret_vld  && (state_q == FILL_I);
  assign bus.d_fill_we    = ret_vld  && (state_q == FILL_D);
  assign bus.i_fill_done  = ret_last && (state_q == FILL_I);
  assign bus.d_fill_done  = ret_last && (state_q == FILL_D);
  assign bus.i_cache_busy = bus.i_miss_req & ~bus.i_fill_done;
  assign bus.d_cache_busy = (bus.d_miss_req & ~bus.d_fill_done) | (bus.d_wr_req & ~wr_ack_q);
endmodule
